ide_pio_sequencer: RTL

Cycle-accurate sequencer for the board's IDE/boot-ROM window on the 68000 bus. It replaces free-running strobe generation with programmable ATA PIO phases: address setup, strobe active, CS hold, and recovery. It also generates DTACK_n and keeps the rule that reads go to the ROM until the first write.
It sits between CPU bus decode (base address from the autoconfig block) and the IDE connector / ROM OE pin.

---
 rtl/ide_pkg.sv | 24 ++
 rtl/ide_pio_sequencer_if.sv | 30 +++
 rtl/ide_phase_timer.sv | 27 ++
 rtl/ide_pio_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ide_pkg.sv
// rtl/ide_pkg.sv - shared states, default timings and helpers for the IDE PIO sequencer
package ide_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        ACK,
        HOLD,
        RECOVER
    } ide_state_t;

    localparam int DEF_CNT_W    = 4;
    localparam int DEF_T1_CYC   = 2;
    localparam int DEF_T2_CYC   = 6;
    localparam int DEF_T9_CYC   = 1;
    localparam int DEF_TREC_CYC = 4;

    // A phase of zero cycles cannot be expressed by the down-counter, so it runs as one.
    function automatic int clamp_cyc(input int cyc);
        return (cyc < 1) ? 1 : cyc;
    endfunction

endpackage

// File: rtl/ide_pio_sequencer_if.sv
// rtl/ide_pio_sequencer_if.sv - CPU bus decode inputs and IDE/ROM/DTACK outputs of the sequencer
interface ide_pio_sequencer_if;

    logic       AS_CPU_n;
    logic       RW_n;
    logic [7:0] A_HIGH;
    logic       A12;
    logic       A13;
    logic [7:0] BASE_IDE;
    logic       IDE_CONFIGURED_n;

    logic [1:0] IDE_CS_n;
    logic       IDE_IOR_n;
    logic       IDE_IOW_n;
    logic       ROM_OE_n;
    logic       DTACK_n;
    logic       IDE_ACCESS;
    logic       BUSY;

    modport master (
        output AS_CPU_n, RW_n, A_HIGH, A12, A13, BASE_IDE, IDE_CONFIGURED_n,
        input  IDE_CS_n, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, DTACK_n, IDE_ACCESS, BUSY
    );

    modport slave (
        input  AS_CPU_n, RW_n, A_HIGH, A12, A13, BASE_IDE, IDE_CONFIGURED_n,
        output IDE_CS_n, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, DTACK_n, IDE_ACCESS, BUSY
    );

endinterface

// File: rtl/ide_phase_timer.sv
// rtl/ide_phase_timer.sv - loadable down-counter that times each sequencer phase
module ide_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             CLKCPU,
    input  logic             RESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    assign zero = (count == '0);

    // Holds at zero until the next phase reloads it.
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!zero) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ide_pio_sequencer.sv
// rtl/ide_pio_sequencer.sv - ATA PIO phase sequencer with boot-ROM window and DTACK generation
module ide_pio_sequencer
    import ide_pkg::*;
#(
    parameter int T1_CYC   = DEF_T1_CYC,
    parameter int T2_CYC   = DEF_T2_CYC,
    parameter int T9_CYC   = DEF_T9_CYC,
    parameter int TREC_CYC = DEF_TREC_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                CLKCPU,
    input  logic                RESET,
    ide_pio_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] T1_LD   = CNT_W'(clamp_cyc(T1_CYC) - 1);
    localparam logic [CNT_W-1:0] T2_LD   = CNT_W'(clamp_cyc(T2_CYC) - 1);
    localparam logic [CNT_W-1:0] T9_LD   = CNT_W'(clamp_cyc(T9_CYC) - 1);
    localparam logic [CNT_W-1:0] TREC_LD = CNT_W'(clamp_cyc(TREC_CYC) - 1);

    ide_state_t       state, state_nxt;
    logic             rw_q, rw_nxt;
    logic             rom_q, rom_nxt;
    logic [1:0]       cs_q, cs_nxt;
    logic             ide_en_q, ide_en_nxt;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    logic [1:0]       cs_out_q, cs_out_nxt;
    logic             ior_q, ior_nxt;
    logic             iow_q, iow_nxt;
    logic             oe_q, oe_nxt;
    logic             dtack_q, dtack_nxt;
    logic             access_q, access_nxt;
    logic             busy_q, busy_nxt;

    logic             sel;

    assign sel = !bus.IDE_CONFIGURED_n && (bus.A_HIGH == bus.BASE_IDE) && !bus.AS_CPU_n;

    ide_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLKCPU   (CLKCPU),
        .RESET    (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state    <= IDLE;
            rw_q     <= 1'b1;
            rom_q    <= 1'b0;
            cs_q     <= 2'b11;
            ide_en_q <= 1'b0;
            cs_out_q <= 2'b11;
            ior_q    <= 1'b1;
            iow_q    <= 1'b1;
            oe_q     <= 1'b1;
            dtack_q  <= 1'b1;
            access_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            rw_q     <= rw_nxt;
            rom_q    <= rom_nxt;
            cs_q     <= cs_nxt;
            ide_en_q <= ide_en_nxt;
            cs_out_q <= cs_out_nxt;
            ior_q    <= ior_nxt;
            iow_q    <= iow_nxt;
            oe_q     <= oe_nxt;
            dtack_q  <= dtack_nxt;
            access_q <= access_nxt;
            busy_q   <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rw_nxt     = rw_q;
        rom_nxt    = rom_q;
        cs_nxt     = cs_q;
        ide_en_nxt = ide_en_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state)
            IDLE: begin
                if (sel) begin
                    rw_nxt    = bus.RW_n;
                    cs_nxt    = ~{bus.A13, bus.A12};
                    rom_nxt   = bus.RW_n && !ide_en_q;
                    if (!bus.RW_n) begin
                        ide_en_nxt = 1'b1;
                    end
                    tmr_load  = 1'b1;
                    tmr_val   = T1_LD;
                    state_nxt = SETUP;
                end
            end
            SETUP, STROBE: begin
                // The CPU dropping AS before DTACK aborts straight into CS hold.
                if (bus.AS_CPU_n) begin
                    tmr_load  = 1'b1;
                    tmr_val   = T9_LD;
                    state_nxt = HOLD;
                end else if (tmr_zero) begin
                    if (state == SETUP) begin
                        tmr_load  = 1'b1;
                        tmr_val   = T2_LD;
                        state_nxt = STROBE;
                    end else begin
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                if (bus.AS_CPU_n) begin
                    tmr_load  = 1'b1;
                    tmr_val   = T9_LD;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_val   = TREC_LD;
                    state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                if (tmr_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        cs_out_nxt = 2'b11;
        ior_nxt    = 1'b1;
        iow_nxt    = 1'b1;
        oe_nxt     = 1'b1;
        dtack_nxt  = 1'b1;
        access_nxt = 1'b0;
        busy_nxt   = (state_nxt != IDLE);

        if (state_nxt inside {SETUP, STROBE, ACK, HOLD}) begin
            cs_out_nxt = rom_nxt ? 2'b11 : cs_nxt;
            access_nxt = !rom_nxt;
        end

        if (state_nxt inside {STROBE, ACK}) begin
            if (!rw_nxt) begin
                iow_nxt = 1'b0;
            end else if (rom_nxt) begin
                oe_nxt = 1'b0;
            end else begin
                ior_nxt = 1'b0;
            end
        end

        if (state_nxt == ACK) begin
            dtack_nxt = 1'b0;
        end
    end

    assign bus.IDE_CS_n   = cs_out_q;
    assign bus.IDE_IOR_n  = ior_q;
    assign bus.IDE_IOW_n  = iow_q;
    assign bus.ROM_OE_n   = oe_q;
    assign bus.DTACK_n    = dtack_q;
    assign bus.IDE_ACCESS = access_q;
    assign bus.BUSY       = busy_q;

endmodule
